// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: the buffered entry layout
// and the stall skid margin.
package fetch_queue_pkg;

    localparam int FQ_INST_WIDTH      = 32;
    localparam int FQ_INST_ADDR_WIDTH = 32;
    localparam int FQ_SKID            = 2;

    typedef struct packed {
        logic [FQ_INST_WIDTH-1:0]      inst;
        logic [FQ_INST_ADDR_WIDTH-1:0] pc;
        logic [FQ_INST_ADDR_WIDTH-1:0] pc_plus_4;
    } fetch_entry_t;

    // Zero an entry unless it is backed by a live queue slot.
    function automatic fetch_entry_t fq_mask_entry(input fetch_entry_t entry, input logic live);
        fetch_entry_t res;
        if (live) begin
            res = entry;
        end else begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bus: fetch register push side, decode pop side and the
// stall back to fetch.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic                          fetch_valid;
    logic [FQ_INST_WIDTH-1:0]      fetch_inst;
    logic [FQ_INST_ADDR_WIDTH-1:0] fetch_pc;
    logic [FQ_INST_ADDR_WIDTH-1:0] fetch_pc_plus_4;
    logic                          stall;
    logic                          dec_valid;
    logic                          dec_ready;
    logic [FQ_INST_WIDTH-1:0]      dec_inst;
    logic [FQ_INST_ADDR_WIDTH-1:0] dec_pc;
    logic [FQ_INST_ADDR_WIDTH-1:0] dec_pc_plus_4;

    modport master (
        output fetch_valid, fetch_inst, fetch_pc, fetch_pc_plus_4, dec_ready,
        input  stall, dec_valid, dec_inst, dec_pc, dec_pc_plus_4
    );

    modport slave (
        input  fetch_valid, fetch_inst, fetch_pc, fetch_pc_plus_4, dec_ready,
        output stall, dec_valid, dec_inst, dec_pc, dec_pc_plus_4
    );

endinterface

// File: rtl/fetch_queue_storage.sv
// Entry storage for the fetch queue: one write port, one asynchronous read
// port, no reset (slots are only read after being written).
module fetch_queue_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  fetch_entry_t             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output fetch_entry_t             rd_data
);

    fetch_entry_t mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between the registered fetch stage and decode: in-order
// queue with early stall, redirect flush and a sticky dropped-push flag.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int INST_ADDR_WIDTH = FQ_INST_ADDR_WIDTH,
    parameter int SKID            = FQ_SKID
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_queue_if.slave           fq,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - SKID);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_err_r;

    logic          full_s;
    logic          dec_valid_s;
    logic          pop_s;
    logic          push_s;
    logic          overflow_s;
    logic [CW-1:0] count_nxt_s;
    fetch_entry_t  wr_entry_s;
    fetch_entry_t  head_entry_s;
    fetch_entry_t  dec_entry_s;
    logic [INST_ADDR_WIDTH-1:0] dec_pc_s;
    logic [INST_ADDR_WIDTH-1:0] dec_pc_plus_4_s;

    assign full_s      = (count_r == FULL_LVL);
    assign dec_valid_s = (count_r != {CW{1'b0}});
    assign pop_s       = dec_valid_s & fq.dec_ready;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_s      = fq.fetch_valid & ~flush & (~full_s | pop_s);
    assign overflow_s  = fq.fetch_valid & ~flush & full_s & ~pop_s;

    assign wr_entry_s.inst      = fq.fetch_inst;
    assign wr_entry_s.pc        = fq.fetch_pc;
    assign wr_entry_s.pc_plus_4 = fq.fetch_pc_plus_4;

    fetch_queue_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push_s & ~reset),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_entry_s),
        .rd_addr (rd_ptr_r),
        .rd_data (head_entry_s)
    );

    // Occupancy after this edge's push/pop (flush handled in the register).
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy and error state; reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            overflow_err_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_nxt_s;
            if (overflow_s) begin
                overflow_err_r <= 1'b1;
            end
        end
    end

    // Head entry forced to zero while the queue is empty.
    always_comb begin
        dec_entry_s     = fq_mask_entry(head_entry_s, dec_valid_s);
        dec_pc_s        = dec_entry_s.pc;
        dec_pc_plus_4_s = dec_entry_s.pc_plus_4;
    end

    assign fq.dec_valid     = dec_valid_s;
    assign fq.dec_inst      = dec_entry_s.inst;
    assign fq.dec_pc        = dec_pc_s;
    assign fq.dec_pc_plus_4 = dec_pc_plus_4_s;
    // Stall comes from registered occupancy only, leaving SKID slots for
    // instructions already in flight from fetch.
    assign fq.stall         = (count_r >= STALL_LVL);
    assign count            = count_r;
    assign overflow_err     = overflow_err_r;

endmodule
